pio_cmd_sequencer: RTL and testbench

//  Accepts HPS instructions delivered over PIO (29-bit instruction + enable strobe), decodes them,

---
 rtl/pio_cmd_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_pio_cmd_sequencer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pio_cmd_sequencer.sv
// pio_cmd_sequencer
//   Takes HPS instructions from a PIO export. The fields are op [2:0], addr [19:3],
//   wdata [27:20] and mode [28]. A rising edge of pio_enable submits the word.
//   The block decodes each command and issues it to the coprocessor datapath with a
//   req/ack handshake, one command at a time. It reports status flags and the last
//   LOAD result back to the HPS. A watchdog aborts datapath commands that never ack.
//
//   Handshake: dp_req rises when a command enters ISSUE and stays high, with
//   dp_op/dp_addr/dp_wdata/dp_mode held stable, until the cycle that dp_ack=1.
//   dp_rdata and dp_err are sampled only on the dp_req&dp_ack cycle.
//
// Ports
//   clk_clk, reset_reset        clock, synchronous active-high reset
//   pio_instruct, pio_enable    instruction word and submit strobe (rising edge)
//   pio_flags                   [0] done [1] error [2] busy [3] overflow
//   pio_data_out                result of the last successful LOAD
//   dp_req/op/addr/wdata/mode   datapath command outputs
//   dp_ack, dp_rdata, dp_err    datapath response inputs
module pio_cmd_sequencer #(
    parameter int OP_W    = 3,
    parameter int ADDR_W  = 17,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024,
    parameter int CNT_W   = 16
) (
    input  logic                           clk_clk,
    input  logic                           reset_reset,
    input  logic [OP_W+ADDR_W+DATA_W:0]    pio_instruct,
    input  logic                           pio_enable,
    output logic [3:0]                     pio_flags,
    output logic [DATA_W-1:0]              pio_data_out,
    output logic                           dp_req,
    output logic [OP_W-1:0]                dp_op,
    output logic [ADDR_W-1:0]              dp_addr,
    output logic [DATA_W-1:0]              dp_wdata,
    output logic                           dp_mode,
    input  logic                           dp_ack,
    input  logic [DATA_W-1:0]              dp_rdata,
    input  logic                           dp_err
);

    localparam logic [OP_W-1:0]  OP_NOP     = OP_W'(0);
    localparam logic [OP_W-1:0]  OP_LOAD    = OP_W'(1);
    localparam logic [OP_W-1:0]  OP_DPRESET = OP_W'(4);
    // Last watchdog count before abort; unused when TIMEOUT is 0.
    localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DECODE   = 2'd1,
        S_ISSUE    = 2'd2,
        S_COMPLETE = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic                en_q, en_d;
    logic [OP_W-1:0]     op_q, op_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                mode_q, mode_d;
    logic [CNT_W-1:0]    wdog_q, wdog_d;
    logic                cmd_err_q, cmd_err_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                submit;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state_q   <= S_IDLE;
            en_q      <= 1'b0;
            op_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            mode_q    <= 1'b0;
            wdog_q    <= '0;
            cmd_err_q <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            ovf_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            mode_q    <= mode_d;
            wdog_q    <= wdog_d;
            cmd_err_q <= cmd_err_d;
            done_q    <= done_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
            ovf_q     <= ovf_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        en_d      = pio_enable;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mode_d    = mode_q;
        wdog_d    = wdog_q;
        cmd_err_d = cmd_err_q;
        done_d    = done_q;
        error_d   = error_q;
        busy_d    = busy_q;
        ovf_d     = ovf_q;
        data_d    = data_q;
        submit    = pio_enable & ~en_q;

        case (state_q)
            S_IDLE: begin
                if (submit) begin
                    op_d    = pio_instruct[OP_W-1:0];
                    addr_d  = pio_instruct[OP_W+ADDR_W-1:OP_W];
                    wdata_d = pio_instruct[OP_W+ADDR_W+DATA_W-1:OP_W+ADDR_W];
                    mode_d  = pio_instruct[OP_W+ADDR_W+DATA_W];
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    ovf_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_q != OP_NOP && op_q <= OP_DPRESET) begin
                    wdog_d  = '0;
                    state_d = S_ISSUE;
                end else begin
                    // NOP completes cleanly; codes above DPRESET are illegal.
                    cmd_err_d = (op_q > OP_DPRESET);
                    state_d   = S_COMPLETE;
                end
            end
            S_ISSUE: begin
                // An ack on the watchdog's last cycle takes priority over the abort.
                if (dp_ack) begin
                    cmd_err_d = dp_err;
                    if (op_q == OP_LOAD && !dp_err) begin
                        data_d = dp_rdata;
                    end
                    state_d = S_COMPLETE;
                end else if (TIMEOUT != 0 && wdog_q == WDOG_LAST) begin
                    cmd_err_d = 1'b1;
                    state_d   = S_COMPLETE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_COMPLETE: begin
                done_d  = 1'b1;
                error_d = cmd_err_q;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A submit while a command is in flight is dropped but remembered.
        if (state_q != S_IDLE && submit) begin
            ovf_d = 1'b1;
        end
    end

    assign dp_req       = (state_q == S_ISSUE);
    assign dp_op        = op_q;
    assign dp_addr      = addr_q;
    assign dp_wdata     = wdata_q;
    assign dp_mode      = mode_q;
    assign pio_flags    = {ovf_q, busy_q, error_q, done_q};
    assign pio_data_out = data_q;

endmodule

// File: tb/tb_pio_cmd_sequencer.sv
module tb_pio_cmd_sequencer;

    localparam int TO = 8;

    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic [28:0] pio_instruct = '0;
    logic        pio_enable = 1'b0;
    logic [3:0]  pio_flags;
    logic [7:0]  pio_data_out;
    logic        dp_req;
    logic [2:0]  dp_op;
    logic [16:0] dp_addr;
    logic [7:0]  dp_wdata;
    logic        dp_mode;
    logic        dp_ack = 1'b0;
    logic [7:0]  dp_rdata = '0;
    logic        dp_err = 1'b0;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_data = 8'h00;

    pio_cmd_sequencer #(.TIMEOUT(TO)) dut (
        .clk_clk      (clk_clk),
        .reset_reset  (reset_reset),
        .pio_instruct (pio_instruct),
        .pio_enable   (pio_enable),
        .pio_flags    (pio_flags),
        .pio_data_out (pio_data_out),
        .dp_req       (dp_req),
        .dp_op        (dp_op),
        .dp_addr      (dp_addr),
        .dp_wdata     (dp_wdata),
        .dp_mode      (dp_mode),
        .dp_ack       (dp_ack),
        .dp_rdata     (dp_rdata),
        .dp_err       (dp_err)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_clk);
        #1;
    endtask

    // Issues one command and plays the datapath. ack_k is the dp_req cycle (1-based)
    // on which the datapath acks; 0 means it never acks. ovf_at raises a second enable
    // edge at that cycle after submit. hold_en keeps enable high after the submit.
    task automatic do_cmd(input string name, input logic [2:0] op, input logic [16:0] addr,
                          input logic [7:0] wdata, input logic mode, input int ack_k,
                          input logic [7:0] rdata, input logic err, input int ovf_at,
                          input bit hold_en);
        bit         legal;
        int         exp_reqs, exp_done_c;
        logic       exp_err;
        logic [3:0] exp_flags;
        int         c, reqs, first_c, done_c, field_bad;

        // Reference outcome from the command rules.
        legal = (op >= 3'd1 && op <= 3'd4);
        if (!legal) begin
            exp_reqs   = 0;
            exp_err    = (op >= 3'd5);
            exp_done_c = 3;
        end else begin
            if (ack_k != 0 && ack_k <= TO) begin
                exp_reqs = ack_k;
                exp_err  = err;
                if (op == 3'd1 && !err) exp_data = rdata;
            end else begin
                exp_reqs = TO;
                exp_err  = 1'b1;
            end
            exp_done_c = exp_reqs + 3;
        end
        exp_flags = {(ovf_at != 0), 1'b0, exp_err, 1'b1};

        pio_instruct = {mode, wdata, addr, op};
        pio_enable   = 1'b1;
        step();
        c = 1; reqs = 0; first_c = 0; done_c = 0; field_bad = 0;
        check({name, "_busy"}, pio_flags[2], 1'b1);
        while (done_c == 0 && c < 60) begin
            if (c == 1 && !hold_en) pio_enable = 1'b0;
            if (ovf_at != 0 && c == ovf_at) pio_enable = 1'b1;
            if (ovf_at != 0 && c == ovf_at + 1) pio_enable = 1'b0;
            if (pio_flags[0]) done_c = c;
            if (dp_req) begin
                reqs++;
                if (first_c == 0) first_c = c;
                if (dp_op !== op || dp_addr !== addr || dp_wdata !== wdata || dp_mode !== mode)
                    field_bad++;
                dp_ack   = (reqs == ack_k);
                dp_rdata = rdata;
                dp_err   = err;
            end else begin
                dp_ack = 1'b0;
            end
            if (done_c == 0) begin
                step();
                c++;
            end
        end
        dp_ack = 1'b0;
        check({name, "_first_req"}, first_c, legal ? 2 : 0);
        check({name, "_req_cycles"}, reqs, exp_reqs);
        check({name, "_dp_fields"}, field_bad, 0);
        check({name, "_done_cycle"}, done_c, exp_done_c);
        check({name, "_flags"}, pio_flags, exp_flags);
        check({name, "_data_out"}, pio_data_out, exp_data);
        if (hold_en) begin
            step(); step(); step();
            check({name, "_held_no_resubmit"}, pio_flags, exp_flags);
            pio_enable = 1'b0;
            step();
        end
    endtask

    initial begin
        logic [2:0] r_op;
        int         r_k, r_ovf;

        step(); step();
        check("reset_flags", pio_flags, 4'b0000);
        check("reset_data", pio_data_out, 8'h00);
        check("reset_req", dp_req, 1'b0);
        check("reset_dp_fields", {dp_op, dp_addr, dp_wdata, dp_mode}, 29'd0);
        reset_reset = 1'b0;
        step();
        check("idle_flags", pio_flags, 4'b0000);

        do_cmd("load_a5",     3'd1, 17'h00123, 8'h00, 1'b0, 3, 8'hA5, 1'b0, 0, 1'b0);
        do_cmd("store_max",   3'd2, 17'h1FFFF, 8'h3C, 1'b1, 2, 8'h77, 1'b0, 0, 1'b0);
        do_cmd("illegal6",    3'd6, 17'h00001, 8'h11, 1'b0, 1, 8'h00, 1'b0, 0, 1'b0);
        do_cmd("run_timeout", 3'd3, 17'h00040, 8'h00, 1'b0, 0, 8'h00, 1'b0, 0, 1'b0);
        do_cmd("load_ack_at_limit", 3'd1, 17'h00002, 8'h00, 1'b0, TO, 8'h5A, 1'b0, 0, 1'b0);
        do_cmd("load_dp_err", 3'd1, 17'h00003, 8'h00, 1'b0, 2, 8'hEE, 1'b1, 0, 1'b0);
        do_cmd("nop_held",    3'd0, 17'h00000, 8'h00, 1'b0, 1, 8'h00, 1'b0, 0, 1'b1);
        do_cmd("dpreset_ovf", 3'd4, 17'h00010, 8'h22, 1'b1, 5, 8'h00, 1'b0, 3, 1'b0);
        do_cmd("store_clears_ovf", 3'd2, 17'h00011, 8'h33, 1'b0, 1, 8'h00, 1'b0, 0, 1'b0);

        // Reset while a command is waiting for ack.
        pio_instruct = {1'b0, 8'h00, 17'h00099, 3'd3};
        pio_enable   = 1'b1;
        step();
        pio_enable = 1'b0;
        step();
        check("rst_mid_req_before", dp_req, 1'b1);
        reset_reset = 1'b1;
        step();
        check("rst_mid_req", dp_req, 1'b0);
        check("rst_mid_flags", pio_flags, 4'b0000);
        check("rst_mid_data", pio_data_out, 8'h00);
        exp_data    = 8'h00;
        reset_reset = 1'b0;
        step();
        check("rst_after_flags", pio_flags, 4'b0000);
        check("rst_after_req", dp_req, 1'b0);

        for (int i = 0; i < 16; i++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_k   = $urandom_range(0, TO + 2);
            r_ovf = (r_op >= 3'd1 && r_op <= 3'd4 && $urandom_range(0, 3) == 0) ? 3 : 0;
            do_cmd($sformatf("rand%0d", i), r_op, 17'($urandom), 8'($urandom),
                   1'($urandom), r_k, 8'($urandom), ($urandom_range(0, 3) == 0), r_ovf, 1'b0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
